sync_fifo_top: RTL and testbench

- Single-clock, synchronous FIFO top level.
- Buffers data_width_p-bit words in a mem_depth_p-entry RAM and exposes full/empty status flags.
- Sits between a producer (wr_en/data_in) and a consumer (rd_en/data_out) in the same clock domain.
- Internally: one memory instance named FIFO holding array mem, plus write-pointer/full logic and read-pointer/empty logic.

---
 rtl/sync_fifo_top.sv | 85 ++++++++
 tb/tb_sync_fifo_top.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO: a RAM module (instance FIFO), wrap-bit pointers and a registered read port.
// Flags are decoded combinationally from the registered pointers.

module sync_fifo_mem #(
  parameter int W  = 8,
  parameter int D  = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  // Left unreset so benches can preload it hierarchically.
  reg [W-1:0] mem [0:D-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

module sync_fifo_top #(
  parameter int data_width_p = 8,
  parameter int mem_depth_p  = 256,
  parameter int addr_size_p  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [data_width_p-1:0] data_in,
  output logic                    full,
  output logic                    empty,
  output logic [data_width_p-1:0] data_out
);
  localparam int PW = addr_size_p + 1;

  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [data_width_p-1:0] data_out_q, data_out_d, rd_word;
  logic                    wr_ok, rd_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[addr_size_p] != rptr_q[addr_size_p]) &&
                 (wptr_q[addr_size_p-1:0] == rptr_q[addr_size_p-1:0]);

  always_comb begin
    wr_ok      = wr_en && !full;
    rd_ok      = rd_en && !empty;
    wptr_d     = wptr_q + {{(PW-1){1'b0}}, wr_ok};
    rptr_d     = rptr_q + {{(PW-1){1'b0}}, rd_ok};
    data_out_d = rd_ok ? rd_word : data_out_q;
  end

  // A write on a reset edge is suppressed so RAM only changes for accepted pushes.
  sync_fifo_mem #(
    .W (data_width_p),
    .D (mem_depth_p),
    .AW(addr_size_p)
  ) FIFO (
    .clk  (clk),
    .we   (wr_ok && !rst),
    .waddr(wptr_q[addr_size_p-1:0]),
    .wdata(data_in),
    .raddr(rptr_q[addr_size_p-1:0]),
    .rdata(rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      data_out_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
endmodule

// File: tb/tb_sync_fifo_top.sv
// Randomized bench for sync_fifo_top: a queue-based model predicts data_out/empty/full
// per edge; a separate monitor pops predictions at the falling edge and compares.

module tb_sync_fifo_top;
  localparam int W = 8, D = 256, AW = 8;

  logic         clk, rst, wr_en, rd_en;
  logic [W-1:0] data_in, data_out;
  logic         full, empty;

  sync_fifo_top #(.data_width_p(W), .mem_depth_p(D), .addr_size_p(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .full(full), .empty(empty), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dout;
    logic         emp;
    logic         ful;
    string        tag;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  int           n_checks = 0;
  int           n_fail   = 0;
  string        phase    = "init";

  // Model: compute the post-edge FIFO state from the pre-edge occupancy.
  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    exp_t e;
    int   sz;
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    if (r) begin
      mq.delete();
      m_dout = '0;
    end else begin
      sz = mq.size();
      if (rd && sz > 0) m_dout = mq.pop_front();
      if (w && sz < D)  mq.push_back(d);
    end
    e.dout = m_dout;
    e.emp  = (mq.size() == 0);
    e.ful  = (mq.size() == D);
    e.tag  = phase;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e.dout || empty !== e.emp || full !== e.ful) begin
          n_fail++;
          $display("FAIL %s: got data_out=%02h empty=%b full=%b, expected data_out=%02h empty=%b full=%b",
                   e.tag, data_out, empty, full, e.dout, e.emp, e.ful);
        end
      end
    end
  end

  initial begin : stim
    int bias;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; m_dout = '0;

    phase = "reset";
    repeat (2) step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    phase = "basic_order";
    for (int i = 0; i < 20; i++) step(0, 1, 0, W'($urandom));
    for (int i = 0; i < 20; i++) step(0, 0, 1, 8'h00);

    phase = "fill_full";
    for (int i = 0; i < D; i++) step(0, 1, 0, W'($urandom_range(0, 254)));
    step(0, 1, 0, 8'hFF);
    phase = "drain_full";
    for (int i = 0; i < D; i++) step(0, 0, 1, 8'h00);

    phase = "underflow";
    step(0, 1, 0, 8'h5A);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'hC3);
    step(0, 0, 1, 8'h00);

    phase = "advance";
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 250; i++) begin
      step(0, 1, 0, W'($urandom));
      step(0, 0, 1, 8'h00);
    end
    phase = "wrap_half";
    for (int i = 0; i < D/2; i++) step(0, 1, 0, W'($urandom));
    phase = "wrap_simul";
    for (int i = 0; i < 20; i++) step(0, 1, 1, W'($urandom));
    phase = "wrap_fill";
    for (int i = 0; i < D/2; i++) step(0, 1, 0, W'($urandom));
    phase = "full_simul";
    step(0, 1, 1, 8'hEE);
    phase = "wrap_drain";
    for (int i = 0; i < D; i++) step(0, 0, 1, 8'h00);

    phase = "mid_reset";
    for (int i = 0; i < 10; i++) step(0, 1, 0, W'($urandom));
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h77);
    step(0, 0, 1, 8'h00);

    phase = "random";
    for (int blk = 0; blk < 8; blk++) begin
      bias = (blk % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 100; i++)
        step(0, ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < (100 - bias)),
             W'($urandom));
    end
    step(0, 0, 0, 8'h00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
